// File: rtl/id_alu_latch.sv
// ID/ALU pipeline register with load-use interlock.
// Captures the decoded instruction and forwarded operands at the end of ID,
// inserts a bubble when an operand depends on a load sitting in ALU, honours
// downstream hold and branch flush, and counts load-use bubbles (saturating).
//
// Ports:
//   gclk, grst_n          clock, asynchronous active-low reset
//   ID_*                  decoded instruction and operand data from ID
//   ALU_Hold              ALU stage cannot accept a new instruction
//   Flush                 squash the instruction currently in ID
//   StallCntClr           synchronous clear of StallCount
//   ID_Stall              combinational: ID/IF must hold this cycle
//   ALU_*                 registered instruction presented to the ALU stage
//   StallCount            saturating load-use bubble counter
module id_alu_latch #(
  parameter int unsigned WORD_WIDTH     = 16,
  parameter int unsigned REG_ADDR_WIDTH = 3,
  parameter int unsigned CBUS_WIDTH     = 24,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      gclk,
  input  logic                      grst_n,
  input  logic                      ID_Valid,
  input  logic [CBUS_WIDTH-1:0]     ID_ControlBus,
  input  logic                      ID_WbEnable,
  input  logic                      ID_MemRead,
  input  logic [REG_ADDR_WIDTH-1:0] ID_WbAddr,
  input  logic [REG_ADDR_WIDTH-1:0] ID_RegDstAddr,
  input  logic [REG_ADDR_WIDTH-1:0] ID_RegSrcAddr,
  input  logic [REG_ADDR_WIDTH-1:0] ID_RegExtAddr,
  input  logic                      ID_UseDst,
  input  logic                      ID_UseSrc,
  input  logic                      ID_UseExt,
  input  logic [WORD_WIDTH-1:0]     ID_RegDstData,
  input  logic [WORD_WIDTH-1:0]     ID_RegSrcData,
  input  logic [WORD_WIDTH-1:0]     ID_RegExtData,
  input  logic                      ALU_Hold,
  input  logic                      Flush,
  input  logic                      StallCntClr,
  output logic                      ID_Stall,
  output logic                      ALU_Valid,
  output logic                      ALU_WbEnable,
  output logic                      ALU_MemRead,
  output logic [REG_ADDR_WIDTH-1:0] ALU_WbAddr,
  output logic [CBUS_WIDTH-1:0]     ALU_ControlBus,
  output logic [WORD_WIDTH-1:0]     ALU_DstData,
  output logic [WORD_WIDTH-1:0]     ALU_SrcData,
  output logic [WORD_WIDTH-1:0]     ALU_ExtData,
  output logic [CNT_WIDTH-1:0]      StallCount
);

  logic flush_pending;
  logic load_in_alu;
  logic operand_hit;
  logic load_use;
  logic bubble;

  // Hazard detection: only operands that are actually read can stall.
  always_comb begin
    load_in_alu = ALU_Valid & ALU_MemRead & ALU_WbEnable;
    operand_hit = (ID_UseDst & (ID_RegDstAddr == ALU_WbAddr)) |
                  (ID_UseSrc & (ID_RegSrcAddr == ALU_WbAddr)) |
                  (ID_UseExt & (ID_RegExtAddr == ALU_WbAddr));
    load_use    = load_in_alu & ID_Valid & operand_hit;
    ID_Stall    = ALU_Hold | load_use;
    bubble      = Flush | flush_pending | load_use;
  end

  // Pipeline register; a flush seen during a hold is remembered so it
  // turns into exactly one bubble on the first non-hold edge.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      flush_pending  <= 1'b0;
      ALU_Valid      <= 1'b0;
      ALU_WbEnable   <= 1'b0;
      ALU_MemRead    <= 1'b0;
      ALU_WbAddr     <= '0;
      ALU_ControlBus <= '0;
      ALU_DstData    <= '0;
      ALU_SrcData    <= '0;
      ALU_ExtData    <= '0;
    end else if (ALU_Hold) begin
      if (Flush) flush_pending <= 1'b1;
    end else if (bubble) begin
      flush_pending  <= 1'b0;
      ALU_Valid      <= 1'b0;
      ALU_WbEnable   <= 1'b0;
      ALU_MemRead    <= 1'b0;
      ALU_WbAddr     <= '0;
      ALU_ControlBus <= '0;
      ALU_DstData    <= '0;
      ALU_SrcData    <= '0;
      ALU_ExtData    <= '0;
    end else begin
      ALU_Valid      <= ID_Valid;
      ALU_WbEnable   <= ID_Valid & ID_WbEnable;
      ALU_MemRead    <= ID_Valid & ID_MemRead;
      ALU_WbAddr     <= ID_WbAddr;
      ALU_ControlBus <= ID_ControlBus;
      ALU_DstData    <= ID_RegDstData;
      ALU_SrcData    <= ID_RegSrcData;
      ALU_ExtData    <= ID_RegExtData;
    end
  end

  // Saturating load-use bubble counter; clear wins over increment.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      StallCount <= '0;
    end else if (StallCntClr) begin
      StallCount <= '0;
    end else if (load_use && !ALU_Hold && (StallCount != {CNT_WIDTH{1'b1}})) begin
      StallCount <= StallCount + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_id_alu_latch.sv
// Directed self-checking bench for id_alu_latch. A second instance with a
// 3-bit counter exercises saturation within a short run.
module tb_id_alu_latch;

  logic        gclk = 1'b0;
  logic        grst_n;
  logic        ID_Valid, ID_WbEnable, ID_MemRead;
  logic [23:0] ID_ControlBus;
  logic [2:0]  ID_WbAddr, ID_RegDstAddr, ID_RegSrcAddr, ID_RegExtAddr;
  logic        ID_UseDst, ID_UseSrc, ID_UseExt;
  logic [15:0] ID_RegDstData, ID_RegSrcData, ID_RegExtData;
  logic        ALU_Hold, Flush, StallCntClr;

  logic        ID_Stall, ALU_Valid, ALU_WbEnable, ALU_MemRead;
  logic [2:0]  ALU_WbAddr;
  logic [23:0] ALU_ControlBus;
  logic [15:0] ALU_DstData, ALU_SrcData, ALU_ExtData;
  logic [15:0] StallCount;

  logic        sat_ID_Stall, sat_Valid, sat_WbEnable, sat_MemRead;
  logic [2:0]  sat_WbAddr;
  logic [23:0] sat_ControlBus;
  logic [15:0] sat_DstData, sat_SrcData, sat_ExtData;
  logic [2:0]  sat_StallCount;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic rnd_hold;

  always #5 gclk = ~gclk;

  id_alu_latch dut (
    .gclk(gclk), .grst_n(grst_n), .ID_Valid(ID_Valid), .ID_ControlBus(ID_ControlBus),
    .ID_WbEnable(ID_WbEnable), .ID_MemRead(ID_MemRead), .ID_WbAddr(ID_WbAddr),
    .ID_RegDstAddr(ID_RegDstAddr), .ID_RegSrcAddr(ID_RegSrcAddr), .ID_RegExtAddr(ID_RegExtAddr),
    .ID_UseDst(ID_UseDst), .ID_UseSrc(ID_UseSrc), .ID_UseExt(ID_UseExt),
    .ID_RegDstData(ID_RegDstData), .ID_RegSrcData(ID_RegSrcData), .ID_RegExtData(ID_RegExtData),
    .ALU_Hold(ALU_Hold), .Flush(Flush), .StallCntClr(StallCntClr), .ID_Stall(ID_Stall),
    .ALU_Valid(ALU_Valid), .ALU_WbEnable(ALU_WbEnable), .ALU_MemRead(ALU_MemRead),
    .ALU_WbAddr(ALU_WbAddr), .ALU_ControlBus(ALU_ControlBus), .ALU_DstData(ALU_DstData),
    .ALU_SrcData(ALU_SrcData), .ALU_ExtData(ALU_ExtData), .StallCount(StallCount)
  );

  id_alu_latch #(.CNT_WIDTH(3)) dut_sat (
    .gclk(gclk), .grst_n(grst_n), .ID_Valid(ID_Valid), .ID_ControlBus(ID_ControlBus),
    .ID_WbEnable(ID_WbEnable), .ID_MemRead(ID_MemRead), .ID_WbAddr(ID_WbAddr),
    .ID_RegDstAddr(ID_RegDstAddr), .ID_RegSrcAddr(ID_RegSrcAddr), .ID_RegExtAddr(ID_RegExtAddr),
    .ID_UseDst(ID_UseDst), .ID_UseSrc(ID_UseSrc), .ID_UseExt(ID_UseExt),
    .ID_RegDstData(ID_RegDstData), .ID_RegSrcData(ID_RegSrcData), .ID_RegExtData(ID_RegExtData),
    .ALU_Hold(ALU_Hold), .Flush(Flush), .StallCntClr(StallCntClr), .ID_Stall(sat_ID_Stall),
    .ALU_Valid(sat_Valid), .ALU_WbEnable(sat_WbEnable), .ALU_MemRead(sat_MemRead),
    .ALU_WbAddr(sat_WbAddr), .ALU_ControlBus(sat_ControlBus), .ALU_DstData(sat_DstData),
    .ALU_SrcData(sat_SrcData), .ALU_ExtData(sat_ExtData), .StallCount(sat_StallCount)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge gclk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  // Drive one ID instruction; Dst/Ext data are derived from the Src value.
  task automatic present(input logic v, input logic we, input logic mr, input logic [2:0] wa,
                         input logic [23:0] cb, input logic ud, input logic [2:0] da,
                         input logic us, input logic [2:0] sa, input logic ue,
                         input logic [2:0] ea, input logic [15:0] d);
    ID_Valid = v; ID_WbEnable = we; ID_MemRead = mr; ID_WbAddr = wa; ID_ControlBus = cb;
    ID_UseDst = ud; ID_RegDstAddr = da; ID_UseSrc = us; ID_RegSrcAddr = sa;
    ID_UseExt = ue; ID_RegExtAddr = ea;
    ID_RegSrcData = d; ID_RegDstData = ~d; ID_RegExtData = d + 16'd1;
  endtask

  // False/true hazard table: {load_memread, ud, da, us, sa, ue, ea, expect_stall}
  typedef struct {
    logic mr; logic ud; logic [2:0] da; logic us; logic [2:0] sa;
    logic ue; logic [2:0] ea; logic stall;
  } haz_t;
  haz_t haz[6];

  initial begin
    haz[0] = '{1'b1, 1'b0, 3'd0, 1'b0, 3'd3, 1'b0, 3'd0, 1'b0};
    haz[1] = '{1'b1, 1'b0, 3'd0, 1'b1, 3'd4, 1'b0, 3'd0, 1'b0};
    haz[2] = '{1'b0, 1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 3'd0, 1'b0};
    haz[3] = '{1'b1, 1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1};
    haz[4] = '{1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd3, 1'b1};
    haz[5] = '{1'b1, 1'b0, 3'd3, 1'b1, 3'd2, 1'b0, 3'd3, 1'b0};

    // Reset with random inputs
    grst_n = 1'b0;
    rnd_hold = 1'($urandom());
    present(1'($urandom()), 1'($urandom()), 1'($urandom()), 3'($urandom()), 24'($urandom()),
            1'($urandom()), 3'($urandom()), 1'($urandom()), 3'($urandom()),
            1'($urandom()), 3'($urandom()), 16'($urandom()));
    ALU_Hold = rnd_hold; Flush = 1'($urandom()); StallCntClr = 1'($urandom());
    repeat (3) tick;
    check("rst_valid", 32'(ALU_Valid), 32'd0);
    check("rst_wben", 32'(ALU_WbEnable), 32'd0);
    check("rst_memrd", 32'(ALU_MemRead), 32'd0);
    check("rst_wbaddr", 32'(ALU_WbAddr), 32'd0);
    check("rst_cbus", 32'(ALU_ControlBus), 32'd0);
    check("rst_data", 32'(ALU_SrcData | ALU_DstData | ALU_ExtData), 32'd0);
    check("rst_cnt", 32'(StallCount), 32'd0);
    check("rst_stall", 32'(ID_Stall), 32'(rnd_hold));

    // Release and first instruction
    present(1'b1, 1'b0, 1'b0, 3'd0, 24'h000011, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h1234);
    ALU_Hold = 1'b0; Flush = 1'b0; StallCntClr = 1'b0;
    grst_n = 1'b1;
    settle;
    check("first_stall", 32'(ID_Stall), 32'd0);
    tick;
    check("first_valid", 32'(ALU_Valid), 32'd1);
    check("first_src", 32'(ALU_SrcData), 32'h1234);
    check("first_dst", 32'(ALU_DstData), 32'hEDCB);
    check("first_ext", 32'(ALU_ExtData), 32'h1235);
    check("first_cbus", 32'(ALU_ControlBus), 32'h11);

    // Basic load-use
    present(1'b1, 1'b1, 1'b1, 3'd3, 24'h000022, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0001);
    tick;
    check("ld_memrd", 32'(ALU_MemRead), 32'd1);
    check("ld_wbaddr", 32'(ALU_WbAddr), 32'd3);
    present(1'b1, 1'b1, 1'b0, 3'd5, 24'h000033, 1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 3'd0, 16'h5555);
    settle;
    check("lu_stall", 32'(ID_Stall), 32'd1);
    tick;
    exp_cnt = 1;
    check("lu_bubble_valid", 32'(ALU_Valid), 32'd0);
    check("lu_bubble_cbus", 32'(ALU_ControlBus), 32'd0);
    check("lu_bubble_src", 32'(ALU_SrcData), 32'd0);
    check("lu_bubble_wben", 32'(ALU_WbEnable), 32'd0);
    check("lu_cnt", 32'(StallCount), 32'(exp_cnt));
    check("lu_stall_after", 32'(ID_Stall), 32'd0);
    tick;
    check("lu_latch_valid", 32'(ALU_Valid), 32'd1);
    check("lu_latch_src", 32'(ALU_SrcData), 32'h5555);
    check("lu_latch_wbaddr", 32'(ALU_WbAddr), 32'd5);
    check("lu_latch_cbus", 32'(ALU_ControlBus), 32'h33);

    // Operand-specific hazard table
    for (int i = 0; i < 6; i++) begin
      present(1'b1, 1'b1, haz[i].mr, 3'd3, 24'h000044, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0002);
      tick;
      present(1'b1, 1'b0, 1'b0, 3'd6, 24'h000055, haz[i].ud, haz[i].da, haz[i].us, haz[i].sa,
              haz[i].ue, haz[i].ea, 16'hC000 + 16'(i));
      settle;
      check($sformatf("haz%0d_stall", i), 32'(ID_Stall), 32'(haz[i].stall));
      tick;
      if (haz[i].stall) begin
        exp_cnt++;
        check($sformatf("haz%0d_bubble", i), 32'(ALU_Valid), 32'd0);
        tick;
      end
      check($sformatf("haz%0d_valid", i), 32'(ALU_Valid), 32'd1);
      check($sformatf("haz%0d_src", i), 32'(ALU_SrcData), 32'hC000 + 32'(i));
    end
    check("haz_cnt", 32'(StallCount), 32'(exp_cnt));

    // Invalid ID gates WbEnable/MemRead but still latches fields
    present(1'b0, 1'b1, 1'b1, 3'd2, 24'h000066, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h7777);
    tick;
    check("inv_valid", 32'(ALU_Valid), 32'd0);
    check("inv_wben", 32'(ALU_WbEnable), 32'd0);
    check("inv_memrd", 32'(ALU_MemRead), 32'd0);
    check("inv_src", 32'(ALU_SrcData), 32'h7777);
    check("inv_cbus", 32'(ALU_ControlBus), 32'h66);

    // Load-use under hold: no count, no bubble until hold drops
    present(1'b1, 1'b1, 1'b1, 3'd3, 24'h000077, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0003);
    tick;
    present(1'b1, 1'b1, 1'b0, 3'd1, 24'h000088, 1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 3'd0, 16'h8888);
    ALU_Hold = 1'b1;
    settle;
    check("hlu_stall", 32'(ID_Stall), 32'd1);
    tick;
    check("hlu_held", 32'(ALU_MemRead), 32'd1);
    check("hlu_cnt", 32'(StallCount), 32'(exp_cnt));
    ALU_Hold = 1'b0;
    tick;
    exp_cnt++;
    check("hlu_bubble", 32'(ALU_Valid), 32'd0);
    check("hlu_cnt2", 32'(StallCount), 32'(exp_cnt));
    tick;
    check("hlu_src", 32'(ALU_SrcData), 32'h8888);

    // Hold for 3 cycles with a flush pulse in cycle 2
    present(1'b1, 1'b0, 1'b0, 3'd0, 24'h000099, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 16'hAAAA);
    tick;
    check("hf_a", 32'(ALU_SrcData), 32'hAAAA);
    present(1'b1, 1'b0, 1'b0, 3'd0, 24'h0000BB, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 16'hBBBB);
    ALU_Hold = 1'b1;
    settle;
    check("hf_stall", 32'(ID_Stall), 32'd1);
    tick;
    check("hf_c1", 32'(ALU_SrcData), 32'hAAAA);
    Flush = 1'b1;
    tick;
    Flush = 1'b0;
    check("hf_c2", 32'(ALU_SrcData), 32'hAAAA);
    tick;
    check("hf_c3", 32'(ALU_SrcData), 32'hAAAA);
    check("hf_c3_valid", 32'(ALU_Valid), 32'd1);
    ALU_Hold = 1'b0;
    tick;
    check("hf_bubble_valid", 32'(ALU_Valid), 32'd0);
    check("hf_bubble_src", 32'(ALU_SrcData), 32'd0);
    tick;
    check("hf_resume_valid", 32'(ALU_Valid), 32'd1);
    check("hf_resume_src", 32'(ALU_SrcData), 32'hBBBB);

    // Direct flush without hold
    present(1'b1, 1'b0, 1'b0, 3'd0, 24'h0000CC, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 16'hCCCC);
    Flush = 1'b1;
    tick;
    Flush = 1'b0;
    check("fl_bubble", 32'(ALU_Valid), 32'd0);
    tick;
    check("fl_resume", 32'(ALU_SrcData), 32'hCCCC);

    // Counter clear and saturation
    check("cnt_before_clr", 32'(StallCount), 32'(exp_cnt));
    present(1'b0, 1'b0, 1'b0, 3'd0, 24'h0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0);
    StallCntClr = 1'b1;
    tick;
    StallCntClr = 1'b0;
    check("clr_cnt", 32'(StallCount), 32'd0);
    check("clr_sat", 32'(sat_StallCount), 32'd0);
    present(1'b1, 1'b1, 1'b1, 3'd3, 24'h000001, 1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 3'd0, 16'h0DD0);
    tick;
    for (int i = 0; i < 6; i++) begin
      tick;
      tick;
    end
    check("cnt6", 32'(StallCount), 32'd6);
    check("sat6", 32'(sat_StallCount), 32'd6);
    for (int i = 0; i < 3; i++) begin
      tick;
      tick;
    end
    check("cnt9", 32'(StallCount), 32'd9);
    check("sat_max", 32'(sat_StallCount), 32'd7);
    StallCntClr = 1'b1;
    settle;
    check("clrlu_stall", 32'(ID_Stall), 32'd1);
    tick;
    StallCntClr = 1'b0;
    check("clrlu_cnt", 32'(StallCount), 32'd0);
    check("clrlu_sat", 32'(sat_StallCount), 32'd0);
    check("clrlu_bubble", 32'(ALU_Valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
